// File: rtl/booth_seq_mult_if.sv
// Handshake bundle for the sequential Booth multiplier: operand channel
// (in_valid/in_ready), result channel (out_valid/out_ready) and status.
interface booth_seq_mult_if #(
  parameter int WIDTH = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               signed_mode;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] z;
  logic               busy;

  // Producer/consumer side (drives operands, accepts products)
  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, z, busy
  );

  // Multiplier side
  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, z, busy
  );
endinterface

// File: rtl/booth_seq_mult.sv
// Iterative radix-2 Booth multiplier. Operands are extended to WIDTH+1 bits
// so one datapath covers signed and unsigned products; one Booth step per
// clock through a single shared adder, WIDTH+1 steps per product.
module booth_seq_mult #(
  parameter int WIDTH = 16
) (
  input logic           clk,
  input logic           rst_n,
  booth_seq_mult_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic [WIDTH:0]     acc;        // accumulator A
  logic [WIDTH:0]     q;          // multiplier Q (extended)
  logic [WIDTH:0]     m;          // multiplicand M (extended)
  logic               q_m1;       // Q[-1]
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] product;

  logic [WIDTH+1:0]   addend;
  logic               add_cin;
  logic [WIDTH+1:0]   sum;
  logic [2*WIDTH+1:0] shifted;

  // Shared adder/subtractor: sum is one bit wider than A so the following
  // arithmetic shift always sees the true sign of A +/- M.
  always_comb begin
    addend  = '0;
    add_cin = 1'b0;
    case ({q[0], q_m1})
      2'b01: begin
        addend  = {m[WIDTH], m};
        add_cin = 1'b0;
      end
      2'b10: begin
        addend  = ~{m[WIDTH], m};
        add_cin = 1'b1;
      end
      default: begin
        addend  = '0;
        add_cin = 1'b0;
      end
    endcase
    sum     = {acc[WIDTH], acc} + addend + {{(WIDTH + 1){1'b0}}, add_cin};
    shifted = {sum, q[WIDTH:1]};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and handshake/status outputs decoded from state
  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          state_nxt = CALC;
        end else begin
          state_nxt = IDLE;
        end
      end
      CALC: begin
        bus.busy = 1'b1;
        if (cnt == CW'(1)) begin
          state_nxt = DONE;
        end else begin
          state_nxt = CALC;
        end
      end
      DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = DONE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: operand capture on acceptance, one Booth step per CALC cycle,
  // product latched on the final step and held until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      q       <= '0;
      m       <= '0;
      q_m1    <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            m    <= {bus.signed_mode & bus.a[WIDTH-1], bus.a};
            q    <= {bus.signed_mode & bus.b[WIDTH-1], bus.b};
            acc  <= '0;
            q_m1 <= 1'b0;
            cnt  <= CW'(WIDTH + 1);
          end
        end
        CALC: begin
          acc  <= shifted[2*WIDTH+1:WIDTH+1];
          q    <= shifted[WIDTH:0];
          q_m1 <= q[0];
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            product <= shifted[2*WIDTH-1:0];
          end
        end
        default: begin
          cnt <= cnt;
        end
      endcase
    end
  end

  assign bus.z = product;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Self-checking bench for booth_seq_mult (WIDTH=16): directed corner cases,
// backpressure, mid-operation reset and randomized back-to-back products
// against a plain-arithmetic reference.
module tb_booth_seq_mult;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  booth_seq_mult_if #(.WIDTH(W)) bus ();

  booth_seq_mult #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer product of the operands as interpreted by mode
  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y,
                                                input logic sm);
    longint sx, sy, p;
    if (sm) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end else begin
      sx = longint'({1'b0, x});
      sy = longint'({1'b0, y});
    end
    p = sx * sy;
    return p[2*W-1:0];
  endfunction

  task automatic scramble_inputs();
    bus.in_valid    = 1'($urandom_range(0, 1));
    bus.a           = W'($urandom);
    bus.b           = W'($urandom);
    bus.signed_mode = 1'($urandom_range(0, 1));
  endtask

  // One complete transaction: accept, measure latency, hold under
  // backpressure for 'hold' cycles, then hand off and confirm return to IDLE.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic sm,
                        input logic [2*W-1:0] exp, input int hold, input string tag);
    int lat;
    @(negedge clk);
    bus.a           = ta;
    bus.b           = tbv;
    bus.signed_mode = sm;
    bus.in_valid    = 1'b1;
    bus.out_ready   = 1'b0;
    chk({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    lat = 0;
    while (!bus.out_valid && lat < 4 * W) begin
      scramble_inputs();
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(W + 1));
    chk({tag, " z"}, 64'(bus.z), 64'(exp));
    chk({tag, " busy"}, 64'(bus.busy), 64'd1);
    for (int i = 0; i < hold; i++) begin
      scramble_inputs();
      @(posedge clk);
      #1;
      chk({tag, " hold z"}, 64'(bus.z), 64'(exp));
      chk({tag, " hold in_ready"}, 64'(bus.in_ready), 64'd0);
      chk({tag, " hold out_valid"}, 64'(bus.out_valid), 64'd1);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.a         = W'($urandom);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk({tag, " idle in_ready"}, 64'(bus.in_ready), 64'd1);
    chk({tag, " idle out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, " idle busy"}, 64'(bus.busy), 64'd0);
    chk({tag, " idle z"}, 64'(bus.z), 64'(exp));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rs;
    int           seen;

    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    bus.signed_mode = 1'b0;
    bus.out_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset z", 64'(bus.z), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h8000, 16'h8000, 1'b1, 32'h4000_0000, 0, "signed_min");
    run_op(16'h7FFF, 16'hFFFF, 1'b1, 32'hFFFF_8001, 0, "signed_neg1");
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 0, "unsigned_max");
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001, 0, "signed_m1m1");
    run_op(16'h8000, 16'h7FFF, 1'b1, 32'hC000_8000, 1, "signed_minmax");
    run_op(16'h1234, 16'h00FF, 1'b0, 32'h0012_21CC, 10, "backpressure");

    // Abort an operation partway through CALC with an asynchronous reset
    @(negedge clk);
    bus.a           = 16'h1234;
    bus.b           = 16'h5678;
    bus.signed_mode = 1'b1;
    bus.in_valid    = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async in_ready", 64'(bus.in_ready), 64'd1);
    chk("async out_valid", 64'(bus.out_valid), 64'd0);
    chk("async busy", 64'(bus.busy), 64'd0);
    chk("async z", 64'(bus.z), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    for (int i = 0; i < W + 6; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    chk("aborted no out_valid", 64'(seen), 64'd0);
    run_op(16'h0003, 16'hFFFE, 1'b1, 32'hFFFF_FFFA, 0, "after_reset");

    for (int n = 0; n < 250; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom_range(0, 1));
      run_op(ra, rb, rs, ref_prod(ra, rb, rs), $urandom_range(0, 3), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/booth_seq_mult.md
BOOTH_SEQ_MULT -- requirements
Module: booth_seq_mult

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; legal range 4..32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 in_valid  input  1  operand pair on a/b/signed_mode is valid.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 a  input  WIDTH  multiplicand (M).
REQ-007 b  input  WIDTH  multiplier (Q).
REQ-008 signed_mode  input  1  1 means a and b are two's complement; 0 means unsigned.
REQ-009 out_valid  output  1  z holds a finished product.
REQ-010 out_ready  input  1  consumer accepts z.
REQ-011 z  output  2*WIDTH  product.
REQ-012 busy  output  1  high in CALC or DONE.

Function
REQ-013 The block SHALL be an iterative radix-2 Booth multiplier with one Booth step per clk cycle, using a single shared adder/subtractor.
REQ-014 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 Acceptance SHALL occur on an edge with in_valid=1 and in_ready=1.
  - a, b and signed_mode are captured.
  - Each operand is extended to WIDTH+1 bits: sign-extended if signed_mode=1, zero-extended otherwise.
  - The accumulator A (WIDTH+1 bits) is cleared, Q[-1] is cleared, the step counter is loaded with WIDTH+1, and the FSM enters CALC.
REQ-017 Each CALC cycle SHALL perform one Booth step.
  - The pair {Q[0], Q[-1]} selects the operation: 01 gives A+M, 10 gives A-M, 00 and 11 leave A unchanged.
  - {A, Q, Q[-1]} is then arithmetic-shifted right one bit.
  - The counter decrements.
REQ-018 When the counter reaches 0 after WIDTH+1 steps, the FSM SHALL enter DONE with z = low 2*WIDTH bits of {A, Q}.
REQ-019 Latency SHALL be fixed: out_valid rises exactly WIDTH+1 clk cycles after the acceptance edge, independent of operand values.
REQ-020 z SHALL be registered and held stable while out_valid=1 and out_ready=0, for any duration.
REQ-021 On an edge with out_valid=1 and out_ready=1, the FSM SHALL return to IDLE; in_ready is 1 on the following cycle. There is no same-cycle accept-and-deliver.
REQ-022 in_valid, a, b and signed_mode SHALL be ignored outside IDLE.
REQ-023 Signed products SHALL be exact two's complement over the full range, including -2^(WIDTH-1) * -2^(WIDTH-1).
REQ-024 Unsigned products SHALL be exact for all operands up to (2^WIDTH-1)^2.
REQ-025 z SHALL keep the last product after the return to IDLE, until the next DONE.

Reset
REQ-026 Asserting rst_n low SHALL immediately, with no clock edge required, force the following:
  - FSM to IDLE.
  - in_ready=1, out_valid=0, busy=0.
  - z=0, step counter=0, A/Q/M registers=0.
REQ-027 Reset during CALC or DONE SHALL abort the operation; no out_valid pulse appears for the aborted pair.
REQ-028 After rst_n deasserts, the first rising edge with in_valid=1 SHALL be accepted normally.

Verification (WIDTH=16)
REQ-029 Signed minimum: signed_mode=1, a=0x8000, b=0x8000 -> z=0x40000000, out_valid exactly 17 cycles after acceptance.
REQ-030 Signed by -1: signed_mode=1, a=0x7FFF, b=0xFFFF -> z=0xFFFF8001.
REQ-031 Unsigned maximum: signed_mode=0, a=0xFFFF, b=0xFFFF -> z=0xFFFE0001; the same operands with signed_mode=1 -> z=0x00000001.
REQ-032 Backpressure: out_ready=0 for 10 cycles after out_valid, with in_valid and new a/b toggling meanwhile.
  - Required: z stable, in_ready=0, and the new operands are not captured.
  - On out_ready=1: IDLE is reached on the next cycle, then the next pair is accepted.
REQ-033 Reset mid-operation: rst_n pulsed low at step 8 of CALC.
  - Required: outputs reach reset values asynchronously and no out_valid follows.
  - The next operation, signed 0x0003 * 0xFFFE, yields z=0xFFFFFFFA.
REQ-034 Random: 10^5 random a/b/signed_mode, back-to-back, with random out_ready.
  - Each z must match a golden model.
  - Latency must always be 17 cycles.
  - The same random test is repeated at WIDTH=4 and WIDTH=32.
